// File: rtl/hack_pkg.sv
// hack_pkg: shared word width and RAM8 geometry constants
package hack_pkg;
  localparam int WORD_W = 16;
  localparam int RAM8_DEPTH = 8;
  localparam int RAM8_AW = 3;
endpackage

// File: rtl/register16.sv
// register16: WIDTH-bit register; ports clock, reset (sync clear), load (enable), in, out
module register16 import hack_pkg::*; #(
  parameter int WIDTH = WORD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  always_ff @(posedge clock)
    if (reset) out <= '0;
    else if (load) out <= in;
endmodule

// File: rtl/ram8.sv
// ram8: 8-word RAM; ports clock, reset, in, load, address, out; RAM8_OUTREG_EN gives a registered write-first out
module ram8 import hack_pkg::*; #(
  parameter int WIDTH = WORD_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in,
  input  logic               load,
  input  logic [RAM8_AW-1:0] address,
  output logic [WIDTH-1:0]   out
);
  logic [RAM8_DEPTH-1:0] en;
  logic [WIDTH-1:0] q [RAM8_DEPTH];
  logic [WIDTH-1:0] m4 [4];
  logic [WIDTH-1:0] m2 [2];
  logic [WIDTH-1:0] rd;
  always_comb en = load ? RAM8_DEPTH'(1) << address : '0;
  for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
    register16 #(.WIDTH(WIDTH)) u_reg (
      .clock(clock),
      .reset(reset),
      .load(en[i]),
      .in(in),
      .out(q[i])
    );
  end
  for (genvar i = 0; i < 4; i++) begin : g_m4
    assign m4[i] = address[0] ? q[2*i+1] : q[2*i];
  end
  for (genvar i = 0; i < 2; i++) begin : g_m2
    assign m2[i] = address[1] ? m4[2*i+1] : m4[2*i];
  end
  assign rd = address[2] ? m2[1] : m2[0];
`ifdef RAM8_OUTREG_EN
  always_ff @(posedge clock)
    out <= reset ? '0 : load ? in : rd;
`else
  assign out = rd;
`endif
endmodule
